muldiv_unit: RTL and testbench

//  Multi-cycle MIPS multiply/divide engine for MULT, MULTU, DIV, DIVU, attached to the exec stage.

---
 rtl/muldiv_if.sv | 15 +
 rtl/muldiv_unit.sv | 188 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Exec-stage <-> multiply/divide engine handshake: operands and control in, {hi,lo} result and status out.
interface muldiv_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        busy;
   logic        ok;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, op, a, b, flush, input busy, ok, hi, lo);
   modport slave  (input start, op, a, b, flush, output busy, ok, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS MULT/MULTU/DIV/DIVU engine; ok is a one-cycle result strobe that releases the exec stall.
//
// state | meaning
// IDLE  | waiting for start; hi/lo hold the last result
// MUL   | multiply in flight, counter counts down to the result cycle
// DIV   | first cycle forms operand magnitudes, then 32 restoring steps
// FIX   | apply quotient/remainder signs
// DONE  | ok strobe, hi/lo valid; always returns to IDLE
module muldiv_unit #(
   parameter int MUL_LATENCY = 3,
   parameter int DIV_LATENCY = 34
) (
   input  logic     clk,
   input  logic     resetn,
   muldiv_if.slave  io
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_DIV  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [1:0]  op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvs_q, dvs_d;
   logic        setup_q, setup_d;
   logic        busy_q, busy_d;
   logic        ok_q, ok_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic signed [32:0] mul_a, mul_b;
   logic signed [65:0] mul_p;
   logic [32:0]        shl, diff;
   logic [31:0]        a_mag, b_mag, quo_fix, rem_fix;
   logic               is_signed;

   assign is_signed = ~op_q[0];

   // 33-bit operands let one signed multiplier serve both MULT and MULTU.
   assign mul_a = {is_signed & a_q[31], a_q};
   assign mul_b = {is_signed & b_q[31], b_q};
   assign mul_p = 66'(mul_a) * 66'(mul_b);

   assign shl  = {rem_q, quo_q[31]};
   assign diff = shl - {1'b0, dvs_q};

   // -0x80000000 wraps to itself, which is the correct unsigned magnitude.
   assign a_mag   = (is_signed && a_q[31]) ? -a_q : a_q;
   assign b_mag   = (is_signed && b_q[31]) ? -b_q : b_q;
   assign quo_fix = (is_signed && (a_q[31] ^ b_q[31])) ? -quo_q : quo_q;
   assign rem_fix = (is_signed && a_q[31]) ? -rem_q : rem_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      setup_d = setup_q;
      busy_d  = busy_q;
      ok_d    = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;

      unique case (state_q)
         S_IDLE: begin
            if (io.start) begin
               op_d   = io.op;
               a_d    = io.a;
               b_d    = io.b;
               busy_d = 1'b1;
               if (io.op[1]) begin
                  state_d = S_DIV;
                  cnt_d   = 5'd31;
                  setup_d = 1'b1;
               end else begin
                  state_d = S_MUL;
                  cnt_d   = 5'(MUL_LATENCY - 1);
               end
            end
         end
         S_MUL: begin
            if (cnt_q == 5'd0) begin
               state_d = S_DONE;
               hi_d    = mul_p[63:32];
               lo_d    = mul_p[31:0];
               ok_d    = 1'b1;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         S_DIV: begin
            if (setup_q) begin
               setup_d = 1'b0;
               rem_d   = '0;
               quo_d   = a_mag;
               dvs_d   = b_mag;
            end else begin
               // A zero divisor always "fits", giving an all-ones quotient and rem = |a|.
               if (!diff[32]) begin
                  rem_d = diff[31:0];
                  quo_d = {quo_q[30:0], 1'b1};
               end else begin
                  rem_d = shl[31:0];
                  quo_d = {quo_q[30:0], 1'b0};
               end
               if (cnt_q == 5'd0) state_d = S_FIX;
               else               cnt_d   = cnt_q - 5'd1;
            end
         end
         S_FIX: begin
            state_d = S_DONE;
            hi_d    = rem_fix;
            lo_d    = quo_fix;
            ok_d    = 1'b1;
            busy_d  = 1'b0;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      if (io.flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         setup_d = 1'b0;
         busy_d  = 1'b0;
         ok_d    = 1'b0;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         setup_q <= 1'b0;
         busy_q  <= 1'b0;
         ok_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         setup_q <= setup_d;
         busy_q  <= busy_d;
         ok_q    <= ok_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign io.busy = busy_q;
   assign io.ok   = ok_q;
   assign io.hi   = hi_q;
   assign io.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

   localparam int ML = 3;
   localparam int DL = 34;

   logic clk = 1'b0;
   logic resetn;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [31:0] last_hi, last_lo;

   always #5 clk = ~clk;

   muldiv_if bus ();

   muldiv_unit #(.MUL_LATENCY(ML), .DIV_LATENCY(DL)) dut (
      .clk    (clk),
      .resetn (resetn),
      .io     (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = $signed(a);
      sb = $signed(b);
      case (op)
         2'b00: begin
            p = 64'(sa * sb);
            return p;
         end
         2'b01: begin
            p = {32'd0, a} * {32'd0, b};
            return p;
         end
         2'b10: begin
            if (b == 32'd0) return {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   // Issues one op with start held until the unit has returned to IDLE, as a stalled exec would.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [63:0] exp;
      int cyc;
      int lat;
      bit busy_ok;
      exp = ref_model(op, a, b);
      lat = op[1] ? DL : ML;
      busy_ok = 1'b1;
      bus.start = 1'b1;
      bus.op = op;
      bus.a = a;
      bus.b = b;
      tick();
      cyc = 0;
      while (bus.ok !== 1'b1 && cyc < 80) begin
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
         tick();
         cyc++;
      end
      check({tag, " latency"}, 32'(cyc), 32'(lat));
      check({tag, " busy_while_running"}, {31'd0, busy_ok}, 32'd1);
      check({tag, " busy_at_ok"}, {31'd0, bus.busy}, 32'd0);
      check({tag, " hi"}, bus.hi, exp[63:32]);
      check({tag, " lo"}, bus.lo, exp[31:0]);
      tick();
      check({tag, " single_ok"}, {30'd0, bus.ok, bus.busy}, 32'd0);
      bus.start = 1'b0;
      tick();
      check({tag, " idle_after"}, {30'd0, bus.ok, bus.busy}, 32'd0);
      check({tag, " hold_hi"}, bus.hi, exp[63:32]);
      check({tag, " hold_lo"}, bus.lo, exp[31:0]);
      last_hi = exp[63:32];
      last_lo = exp[31:0];
   endtask

   initial begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      bit          saw_ok;

      resetn = 1'b0;
      bus.start = 1'b0;
      bus.op = 2'b00;
      bus.a = '0;
      bus.b = '0;
      bus.flush = 1'b0;
      last_hi = '0;
      last_lo = '0;
      tick();
      tick();
      check("reset busy", {31'd0, bus.busy}, 32'd0);
      check("reset ok", {31'd0, bus.ok}, 32'd0);
      check("reset hi", bus.hi, 32'd0);
      check("reset lo", bus.lo, 32'd0);
      resetn = 1'b1;
      tick();

      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      check("multu_max spec_hi", last_hi, 32'hFFFF_FFFE);
      check("multu_max spec_lo", last_lo, 32'h0000_0001);
      run_op(2'b00, 32'hFFFF_FFFD, 32'd7, "mult_neg");
      check("mult_neg spec_lo", last_lo, 32'hFFFF_FFEB);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg");
      check("div_neg spec_hi", last_hi, 32'hFFFF_FFFF);
      run_op(2'b11, 32'd100, 32'd0, "divu_zero");
      check("divu_zero spec_hi", last_hi, 32'h0000_0064);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd0, "div_zero_neg");
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      check("div_ovf spec_lo", last_lo, 32'h8000_0000);
      run_op(2'b11, 32'h8000_0000, 32'd3, "divu_big");
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minmin");

      // Flush in the middle of a divide: no ok, results untouched, next op accepted right away.
      bus.start = 1'b1;
      bus.op = 2'b10;
      bus.a = 32'd1000;
      bus.b = 32'd7;
      tick();
      saw_ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (bus.ok === 1'b1) saw_ok = 1'b1;
         tick();
      end
      bus.flush = 1'b1;
      bus.op = 2'b01;
      bus.a = 32'd12345;
      bus.b = 32'd678;
      tick();
      check("flush no_ok", {31'd0, saw_ok | bus.ok}, 32'd0);
      check("flush busy", {31'd0, bus.busy}, 32'd0);
      check("flush hi", bus.hi, last_hi);
      check("flush lo", bus.lo, last_lo);
      bus.flush = 1'b0;
      run_op(2'b01, 32'd12345, 32'd678, "after_flush");

      // start with flush in IDLE must not be accepted.
      bus.start = 1'b1;
      bus.flush = 1'b1;
      tick();
      check("idle_flush busy", {31'd0, bus.busy}, 32'd0);
      tick();
      check("idle_flush ok", {30'd0, bus.ok, bus.busy}, 32'd0);
      bus.start = 1'b0;
      bus.flush = 1'b0;
      tick();

      for (int n = 0; n < 30; n++) begin
         rop = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 9));
            default: ;
         endcase
         run_op(rop, ra, rb, "random");
      end

      // Async reset during a multiply clears everything without waiting for a clock.
      bus.start = 1'b1;
      bus.op = 2'b00;
      bus.a = 32'd9;
      bus.b = 32'd9;
      tick();
      tick();
      resetn = 1'b0;
      #1;
      check("mid_reset busy", {31'd0, bus.busy}, 32'd0);
      check("mid_reset ok", {31'd0, bus.ok}, 32'd0);
      check("mid_reset hi", bus.hi, 32'd0);
      check("mid_reset lo", bus.lo, 32'd0);
      bus.start = 1'b0;
      tick();
      resetn = 1'b1;
      tick();
      run_op(2'b11, 32'd77, 32'd5, "post_reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
